// File: rtl/tc_timer_pkg.sv
// Shared definitions for the bus-mapped timer/counter: FSM states, register
// offsets, CTRL field positions and mode codes.
package tc_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 30;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } state_e;

  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_PRESET = 2'd1;
  localparam logic [1:0] OFF_COUNT  = 2'd2;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;

  localparam logic [1:0] MODE_ONESHOT  = 2'b00;
  localparam logic [1:0] MODE_PERIODIC = 2'b01;

  // Only the exact periodic code reloads; 2'b1x falls back to one-shot.
  function automatic logic is_periodic(input logic [1:0] mode);
    return mode == MODE_PERIODIC;
  endfunction

endpackage

// File: rtl/tc_timer_if.sv
// Processor-side bus of the timer: word address, write strobe/data, read data
// and the interrupt line heading to CP0.
interface tc_timer_if;
  import tc_pkg::*;

  logic [ADDR_W-1:0] Addr;
  logic              WE;
  logic [DATA_W-1:0] Din;
  logic [DATA_W-1:0] Dout;
  logic              IRQ;

  modport master (output Addr, output WE, output Din, input Dout, input IRQ);
  modport slave  (input Addr, input WE, input Din, output Dout, output IRQ);

endinterface

// File: rtl/tc_timer.sv
// Timer/counter responder: CTRL/PRESET/COUNT register file, address decode and
// the IDLE/LOAD/CNT/INT count FSM driving a maskable interrupt.
module tc_timer
  import tc_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
  input  logic       clk,
  input  logic       reset,
  tc_timer_if.slave  bus
);

  state_e            state_q, state_d;
  logic [3:0]        ctrl_q, ctrl_d;
  logic [DATA_W-1:0] preset_q, preset_d;
  logic [DATA_W-1:0] count_q, count_d;
  logic              irq_flag_q, irq_flag_d;

  logic              sel;
  logic [1:0]        off;
  logic              wr_ctrl;
  logic              wr_preset;
  logic              clr_en;
  logic [1:0]        mode;
  logic [DATA_W-1:0] dout;

  // Word address bits [29:2] correspond to byte address bits [31:4].
  assign off       = bus.Addr[1:0];
  assign sel       = (bus.Addr[ADDR_W-1:2] == BASE_ADDR[31:4]) && (off != 2'b11);
  assign wr_ctrl   = bus.WE && sel && (off == OFF_CTRL);
  assign wr_preset = bus.WE && sel && (off == OFF_PRESET);
  assign mode      = ctrl_q[CTRL_MODE_HI:CTRL_MODE_LO];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      ctrl_q     <= '0;
      preset_q   <= '0;
      count_q    <= '0;
      irq_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      preset_q   <= preset_d;
      count_q    <= count_d;
      irq_flag_q <= irq_flag_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ctrl_d     = ctrl_q;
    preset_d   = preset_q;
    count_d    = count_q;
    irq_flag_d = irq_flag_q;
    clr_en     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (ctrl_q[CTRL_EN]) state_d = LOAD;
      end
      LOAD: begin
        count_d = preset_q;
        state_d = CNT;
      end
      CNT: begin
        if (!ctrl_q[CTRL_EN]) begin
          state_d = IDLE;
        end else if (count_q > 32'd1) begin
          count_d = count_q - 32'd1;
        end else begin
          count_d    = '0;
          irq_flag_d = 1'b1;
          state_d    = INT;
        end
      end
      INT: begin
        if (is_periodic(mode)) begin
          irq_flag_d = 1'b0;
          state_d    = LOAD;
        end else begin
          clr_en  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // CPU writes override FSM updates, except the one-shot En clear, which
    // must win so a stray re-enable in the INT cycle cannot restart the count.
    if (wr_ctrl) begin
      ctrl_d     = bus.Din[3:0];
      irq_flag_d = 1'b0;
    end
    if (wr_preset) preset_d = bus.Din;
    if (clr_en) ctrl_d[CTRL_EN] = 1'b0;
  end

  always_comb begin
    dout = '0;
    if (sel) begin
      unique case (off)
        OFF_CTRL:   dout = {{(DATA_W-4){1'b0}}, ctrl_q};
        OFF_PRESET: dout = preset_q;
        OFF_COUNT:  dout = count_q;
        default:    dout = '0;
      endcase
    end
  end

  assign bus.Dout = dout;
  assign bus.IRQ  = irq_flag_q & ctrl_q[CTRL_IM];

endmodule
